inst_fetch_buf: RTL and testbench
=================================

Name: inst_fetch_buf

Overview:
Instruction prefetch queue directly upstream of the BJX1 instruction decoder.
- Fetches aligned 32-bit words from the instruction memory port and splits them into 16-bit halfwords.
- Presents a 48-bit window (three halfwords) as `istrWord` so the decoder can see 32-bit forms and the 8E prefix pair.
- Advances by the decoder's first-op step count (1 or 2 halfwords).
- Flushes and refetches on branch redirect.

Parameters:
- RESET_PC, 32'hA000_0000, fetch PC after reset.
- QDEPTH_LOG2, 3, log2 of halfword queue depth (8 halfwords).

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- memAddr  out  32  fetch address; bits [1:0] always 0.
- memOE  out  1  fetch request; held high with memAddr stable until memOK.
- memData  in  32  fetch data; [15:0] is the lower-address halfword.
- memOK  in  1  fetch acknowledge; memData valid this cycle.
- istrWord  out  48  decode window; [15:0] is the head halfword.
- istrPc  out  32  byte address of head halfword.
- istrValid  out  1  at least 3 halfwords queued.
- stepValid  in  1  decoder consumes the current op this cycle.
- stepLen  in  2  halfwords consumed (decoder idStepPc[1:0]); 1 or 2.
- brValid  in  1  redirect request.
- brPc  in  32  redirect target; bit 0 ignored.

Behaviour:
Reset (synchronous):
- Queue emptied; head/tail pointers = 0.
- istrValid = 0, istrWord = 0, istrPc = RESET_PC.
- memOE = 0, memAddr = RESET_PC & ~3.
- Drop and skip flags cleared.
- Reset asserted mid-request discards any pending response.

Queue:
- 8 x 16-bit entries; 3-bit head/tail pointers wrapping modulo 8.
- 4-bit count, range 0..8.

Outputs:
- istrWord, istrPc and istrValid are combinational from registered state only; no input-to-output paths.

Fetch FSM:
- IDLE: if no redirect this cycle and (count + 2) <= 8, go REQ with memOE = 1.
- REQ: on memOK:
  - if drop = 0: write both halfwords, or only [31:16] when skip = 1, then clear skip.
  - memAddr += 4.
  - go IDLE; memOE falls the same edge.
- At most one request outstanding. Free-space check at issue guarantees room on ack.
- Fill latency: memOK at cycle N → data in queue at edge N → visible from cycle N+1.

Step:
- Accepted only when stepValid & istrValid & !brValid.
- stepLen = 1 or 2: head += stepLen, count -= stepLen, istrPc += 2*stepLen.
- stepLen = 0 or 3: ignored.
- stepValid while istrValid = 0: ignored.

Simultaneous step and memOK write in one cycle:
- count = count + written − stepped.

Redirect (brValid):
- Highest priority; overrides step and write in that cycle.
- Queue flushed, count = 0.
- istrPc = brPc & ~1.
- Next fetch address = brPc & ~3; skip = brPc[1].
- If in REQ without memOK this cycle: set drop = 1, stay in REQ with the old memAddr until memOK, discard that data, then issue from the new address (drop cleared on that ack).
- If memOK arrives in the redirect cycle: data discarded, go IDLE.
- Back-to-back redirects: the last one wins.

Full queue:
- No request issued while count > 6. memOE stays low until the decoder steps.

Decomposition:
- Shared package bjx1_pkg: fetch FSM state encoding (IDLE, REQ), step length constants (1, 2), RESET_PC default.
- One natural sub-module: `hw_queue` (8x16 halfword FIFO with 1- or 2-entry push, 1- or 2-entry pop, flush, count, 3-word peek).
- Fetch FSM stays in the top module.

Test Plan:
1. Reset, memory returns words 0x0009_E101, 0x7104_0009 with memOK one cycle after memOE → istrValid rises 1 cycle after the 2nd ack; istrWord = 0x0009_0009_E101, istrPc = 0xA000_0000.
2. Step sequence stepLen = 1, 2, 1 with continuous 1-cycle memory → istrPc = A000_0000, A000_0002, A000_0006, A000_0008; no halfword lost or duplicated; count never exceeds 8.
3. Hold stepValid = 0 with an always-ready memory → memOE stops after count reaches 7 or 8; no write is dropped.
4. brValid with brPc = 0x8C00_0102 while a request is outstanding (memOK delayed 3 cycles) → stale data discarded; next memAddr = 0x8C00_0100; first queued halfword = memData[31:16]; istrPc = 0x8C00_0102.
5. brValid and stepValid in the same cycle as memOK → queue empty next cycle, istrValid = 0, istrPc = brPc.
6. Assert reset while in REQ awaiting memOK → memOE = 0 next cycle; a late memOK is ignored; fetch restarts at 0xA000_0000.

Source files
------------

// File: rtl/bjx1_pkg.sv
// Shared definitions for the BJX1 fetch path: fetch FSM encoding, decoder step sizes, reset PC.
// Latency: n/a (types, constants and a pure function only).
// Backpressure: n/a.
package bjx1_pkg;

  // Fetch FSM: idle between requests, or one request outstanding on the memory port
  typedef enum logic {
    FETCH_IDLE = 1'b0,
    FETCH_REQ  = 1'b1
  } fetch_state_t;

  // Halfwords the decoder may consume per accepted step
  localparam logic [1:0] STEP_ONE = 2'd1;
  localparam logic [1:0] STEP_TWO = 2'd2;

  localparam logic [31:0] RESET_PC_DEFAULT    = 32'hA000_0000;
  localparam int          QDEPTH_LOG2_DEFAULT = 3;

  // Only 1- and 2-halfword steps move the head; other encodings are treated as no-ops
  function automatic logic step_len_ok(input logic [1:0] len);
    return (len == STEP_ONE) || (len == STEP_TWO);
  endfunction

endpackage

// File: rtl/hw_queue.sv
// Halfword FIFO feeding the decode window: 0/1/2-entry push, 0/1/2-entry pop, flush, 3-entry peek.
// Latency: a push at edge N is visible on peek/count from cycle N+1; peek is purely registered.
// Backpressure: none internally; the caller must only push with room and only pop what is queued.
module hw_queue #(
  parameter int DEPTH_LOG2 = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  flush,
  input  logic [1:0]            push_n,
  input  logic [31:0]           push_dat,
  input  logic [1:0]            pop_n,
  output logic [DEPTH_LOG2:0]   count,
  output logic [47:0]           peek
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2-1:0] IDX_ONE = DEPTH_LOG2'(1);
  localparam logic [DEPTH_LOG2-1:0] IDX_TWO = DEPTH_LOG2'(2);

  logic [15:0]           mem [DEPTH];
  logic [DEPTH_LOG2-1:0] head;
  logic [DEPTH_LOG2-1:0] tail;
  logic [DEPTH_LOG2:0]   cnt;

  // Storage is not reset: nothing downstream looks at an entry before it has been written
  always_ff @(posedge clk) begin
    if (push_n != 2'd0) begin
      mem[tail] <= push_dat[15:0];
    end
    if (push_n == 2'd2) begin
      mem[tail + IDX_ONE] <= push_dat[31:16];
    end
  end

  // Pointer and occupancy update; flush beats push and pop in the same cycle
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      head <= '0;
      tail <= '0;
      cnt  <= '0;
    end else begin
      tail <= tail + DEPTH_LOG2'(push_n);
      head <= head + DEPTH_LOG2'(pop_n);
      cnt  <= cnt + (DEPTH_LOG2+1)'(push_n) - (DEPTH_LOG2+1)'(pop_n);
    end
  end

  assign count = cnt;
  assign peek  = {mem[head + IDX_TWO], mem[head + IDX_ONE], mem[head]};

endmodule

// File: rtl/inst_fetch_buf.sv
// BJX1 instruction prefetch queue: 32-bit fetches split into halfwords, 48-bit decode window.
// Latency: memOK in cycle N -> halfwords queued at edge N -> visible in the window from N+1.
// Backpressure: a fetch is issued only with room for two halfwords; the decoder stalls via istrValid.
module inst_fetch_buf
  import bjx1_pkg::*;
#(
  parameter logic [31:0] RESET_PC    = RESET_PC_DEFAULT,
  parameter int          QDEPTH_LOG2 = QDEPTH_LOG2_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  output logic [31:0] memAddr,
  output logic        memOE,
  input  logic [31:0] memData,
  input  logic        memOK,
  output logic [47:0] istrWord,
  output logic [31:0] istrPc,
  output logic        istrValid,
  input  logic        stepValid,
  input  logic [1:0]  stepLen,
  input  logic        brValid,
  input  logic [31:0] brPc
);

  localparam int DEPTH = 1 << QDEPTH_LOG2;
  localparam int CW    = QDEPTH_LOG2 + 1;
  // Highest occupancy at which a new 2-halfword fetch is still guaranteed to fit on ack
  localparam logic [CW-1:0] ISSUE_MAX = CW'(DEPTH - 2);
  localparam logic [CW-1:0] WIN_HW    = CW'(3);

  fetch_state_t state;
  logic         drop;       // outstanding response belongs to a pre-redirect address
  logic         skip;       // next write keeps only the upper halfword (odd-halfword target)
  logic [31:0]  pend_addr;  // redirect fetch address waiting for the stale ack
  logic [31:0]  pc;

  logic [CW-1:0] count;
  logic [47:0]   peek;
  logic          step_ok;
  logic          wr_en;
  logic [1:0]    push_n;
  logic [1:0]    pop_n;
  logic [31:0]   push_dat;
  logic          has_room;

  assign has_room  = (count <= ISSUE_MAX);
  assign istrValid = (count >= WIN_HW);
  assign istrWord  = istrValid ? peek : '0;
  assign istrPc    = pc;

  // A redirect cancels both the decoder step and any write landing in the same cycle
  assign step_ok  = stepValid && istrValid && !brValid && step_len_ok(stepLen);
  assign wr_en    = (state == FETCH_REQ) && memOK && !drop && !brValid;
  assign pop_n    = step_ok ? stepLen : 2'd0;
  assign push_n   = !wr_en ? 2'd0 : (skip ? 2'd1 : 2'd2);
  assign push_dat = skip ? {16'h0000, memData[31:16]} : memData;

  hw_queue #(
    .DEPTH_LOG2 (QDEPTH_LOG2)
  ) u_queue (
    .clk      (clk),
    .reset    (reset),
    .flush    (brValid),
    .push_n   (push_n),
    .push_dat (push_dat),
    .pop_n    (pop_n),
    .count    (count),
    .peek     (peek)
  );

  // Fetch FSM: one outstanding request, address held until ack, stale data dropped after redirect
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= FETCH_IDLE;
      memOE     <= 1'b0;
      memAddr   <= RESET_PC & ~32'd3;
      pend_addr <= RESET_PC & ~32'd3;
      drop      <= 1'b0;
      skip      <= 1'b0;
    end else begin
      case (state)
        FETCH_IDLE: begin
          if (brValid) begin
            memAddr <= brPc & ~32'd3;
            skip    <= brPc[1];
          end else if (has_room) begin
            state <= FETCH_REQ;
            memOE <= 1'b1;
          end
        end
        FETCH_REQ: begin
          if (memOK) begin
            state <= FETCH_IDLE;
            memOE <= 1'b0;
            drop  <= 1'b0;
            if (brValid) begin
              memAddr <= brPc & ~32'd3;
              skip    <= brPc[1];
            end else if (drop) begin
              // Stale ack consumed; skip still reflects the pending redirect target
              memAddr <= pend_addr;
            end else begin
              memAddr <= memAddr + 32'd4;
              skip    <= 1'b0;
            end
          end else if (brValid) begin
            // Address must stay stable until the ack, so park the new target
            drop      <= 1'b1;
            pend_addr <= brPc & ~32'd3;
            skip      <= brPc[1];
          end
        end
        default: begin
          state <= FETCH_IDLE;
          memOE <= 1'b0;
        end
      endcase
    end
  end

  // Head PC follows accepted steps; a redirect reloads it with the halfword-aligned target
  always_ff @(posedge clk) begin
    if (reset) begin
      pc <= RESET_PC;
    end else if (brValid) begin
      pc <= brPc & ~32'd1;
    end else if (step_ok) begin
      pc <= pc + {29'd0, stepLen, 1'b0};
    end
  end

endmodule

// File: tb/tb_inst_fetch_buf.sv
// Bench for inst_fetch_buf: memory responder with programmable latency and a halfword scoreboard.
// Latency: inputs driven on the falling edge, outputs checked on the next falling edge.
// Backpressure: the bench steps the decoder only as its own model allows.
module tb_inst_fetch_buf;

  localparam logic [31:0] RST_PC = 32'hA000_0000;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] memAddr;
  logic        memOE;
  logic [31:0] memData;
  logic        memOK;
  logic [47:0] istrWord;
  logic [31:0] istrPc;
  logic        istrValid;
  logic        stepValid;
  logic [1:0]  stepLen;
  logic        brValid;
  logic [31:0] brPc;

  int total = 0;
  int bad   = 0;

  // Reference state: queued halfwords, head PC, fetch address, redirect bookkeeping
  logic [15:0] sb[$];
  logic [31:0] exp_pc;
  logic [31:0] exp_addr;
  logic [31:0] pend_addr;
  bit          drop_m;
  bit          skip_m;
  int          lat;
  int          wcnt;
  bit          inj_ok = 1'b0;

  inst_fetch_buf #(
    .RESET_PC    (RST_PC),
    .QDEPTH_LOG2 (3)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .memAddr   (memAddr),
    .memOE     (memOE),
    .memData   (memData),
    .memOK     (memOK),
    .istrWord  (istrWord),
    .istrPc    (istrPc),
    .istrValid (istrValid),
    .stepValid (stepValid),
    .stepLen   (stepLen),
    .brValid   (brValid),
    .brPc      (brPc)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  // Instruction memory contents: two fixed words at the reset vector, else address-derived
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'hA000_0000) return 32'h0009_E101;
    if (a == 32'hA000_0004) return 32'h7104_0009;
    return {a[15:0] + 16'd2, a[15:0]};
  endfunction

  task automatic sample();
    @(negedge clk);
    chk("valid", 64'(istrValid), 64'(sb.size() >= 3));
    chk("pc", 64'(istrPc), 64'(exp_pc));
    if (sb.size() >= 3) chk("word", 64'(istrWord), 64'({sb[2], sb[1], sb[0]}));
    if (memOE) chk("issue_room", 64'(sb.size() <= 6), 64'(1));
  endtask

  // One clock: memory responds, decoder/redirect driven, expectations updated, then check
  task automatic cyc(input bit step = 0, input logic [1:0] len = 2'd0,
                     input bit br = 0, input logic [31:0] bpc = 32'd0);
    bit          ok;
    logic [31:0] d;
    ok = 1'b0;
    if (memOE) begin
      if (wcnt >= lat) begin ok = 1'b1; wcnt = 0; end
      else wcnt++;
    end
    d = ok ? mem_word(memAddr) : 32'hDEAD_BEEF;
    if (ok) chk("fetch_addr", 64'(memAddr), 64'(exp_addr));
    stepValid = step;
    stepLen   = len;
    brValid   = br;
    brPc      = bpc;
    memOK     = ok | inj_ok;
    memData   = d;
    inj_ok    = 1'b0;
    if (br) begin
      sb.delete();
      exp_pc    = bpc & ~32'd1;
      pend_addr = bpc & ~32'd3;
      skip_m    = bpc[1];
      if (memOE && !ok) drop_m = 1'b1;
      else begin drop_m = 1'b0; exp_addr = pend_addr; end
    end else begin
      if (step && (len == 2'd1 || len == 2'd2) && sb.size() >= 3) begin
        repeat (len) void'(sb.pop_front());
        exp_pc += 32'({len, 1'b0});
      end
      if (ok) begin
        if (drop_m) begin
          drop_m   = 1'b0;
          exp_addr = pend_addr;
        end else begin
          if (!skip_m) sb.push_back(d[15:0]);
          sb.push_back(d[31:16]);
          skip_m   = 1'b0;
          exp_addr += 32'd4;
        end
      end
    end
    sample();
  endtask

  task automatic do_reset();
    reset = 1'b1; stepValid = 1'b0; stepLen = 2'd0; brValid = 1'b0; brPc = 32'd0;
    memOK = 1'b0; memData = 32'd0;
    sb.delete();
    exp_pc = RST_PC; exp_addr = RST_PC; pend_addr = RST_PC;
    drop_m = 1'b0; skip_m = 1'b0; wcnt = 0;
    sample();
    chk("rst_oe", 64'(memOE), 64'(0));
    chk("rst_addr", 64'(memAddr), 64'(RST_PC));
    chk("rst_word", 64'(istrWord), 64'(0));
    reset = 1'b0;
  endtask

  task automatic wait_oe(input string tag);
    int n = 0;
    while (!memOE && n < 60) begin cyc(); n++; end
    chk({tag, "_oe_seen"}, 64'(memOE), 64'(1));
  endtask

  initial begin
    int lens[3] = '{1, 2, 1};
    logic [31:0] pcs[3] = '{32'hA000_0002, 32'hA000_0006, 32'hA000_0008};

    // 1: first window after two fetches with one-cycle memory latency
    lat = 1;
    do_reset();
    repeat (5) cyc();
    chk("t1_not_yet", 64'(istrValid), 64'(0));
    cyc();
    chk("t1_valid", 64'(istrValid), 64'(1));
    chk("t1_word", 64'(istrWord), 64'(48'h0009_0009_E101));
    chk("t1_pc", 64'(istrPc), 64'(32'hA000_0000));

    // 2: step sequence 1,2,1 on a full queue, then random steps incl. ignored lengths
    lat = 0;
    do_reset();
    repeat (10) cyc();
    chk("t2_pc0", 64'(istrPc), 64'(32'hA000_0000));
    for (int i = 0; i < 3; i++) begin
      cyc(1'b1, 2'(lens[i]));
      chk("t2_pc_step", 64'(istrPc), 64'(pcs[i]));
    end
    cyc(1'b1, 2'd3);
    chk("t2_len3_ignored", 64'(istrPc), 64'(32'hA000_0008));
    cyc(1'b1, 2'd0);
    chk("t2_len0_ignored", 64'(istrPc), 64'(32'hA000_0008));
    for (int i = 0; i < 40; i++) cyc(1'b1, 2'($urandom_range(0, 3)));

    // 3: decoder stalled, always-ready memory: fetching stops with the queue full
    lat = 0;
    do_reset();
    repeat (30) cyc();
    chk("t3_oe_stopped", 64'(memOE), 64'(0));
    cyc();
    chk("t3_oe_still_low", 64'(memOE), 64'(0));
    repeat (12) cyc(1'b1, 2'd1);

    // 4: redirect to odd-halfword target while a slow request is outstanding
    lat = 3;
    do_reset();
    wait_oe("t4");
    cyc(1'b0, 2'd0, 1'b1, 32'h8C00_0103);
    chk("t4_pc", 64'(istrPc), 64'(32'h8C00_0102));
    chk("t4_addr_held", 64'(memAddr), 64'(RST_PC));
    repeat (24) cyc();
    chk("t4_valid", 64'(istrValid), 64'(1));
    chk("t4_head_hw", 64'(istrWord[15:0]), 64'(16'h0102));

    // 5: redirect, step and ack all in one cycle
    lat = 0;
    do_reset();
    repeat (4) cyc();
    wait_oe("t5");
    cyc(1'b1, 2'd1, 1'b1, 32'h8C00_0200);
    chk("t5_empty", 64'(istrValid), 64'(0));
    chk("t5_pc", 64'(istrPc), 64'(32'h8C00_0200));
    repeat (10) cyc();
    chk("t5_refill_hw", 64'(istrWord[15:0]), 64'(16'h0200));

    // 6: reset while awaiting an ack, then a late ack that must be ignored
    lat = 6;
    do_reset();
    wait_oe("t6");
    cyc();
    cyc();
    do_reset();
    inj_ok = 1'b1;
    cyc();
    lat = 0;
    repeat (8) cyc();
    chk("t6_pc", 64'(istrPc), 64'(RST_PC));
    chk("t6_head_hw", 64'(istrWord[15:0]), 64'(16'hE101));

    // Mixed traffic: random latency, steps and occasional redirects
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 15) == 0) lat = $urandom_range(0, 3);
      cyc($urandom_range(0, 3) != 0, 2'($urandom_range(0, 3)),
          $urandom_range(0, 24) == 0, $urandom);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
